// File: rtl/fsc_pkg.sv
// Shared types and constants for the frame stream checker.
// Holds the controller state encoding, default geometry and the address width helper.
// No logic of its own; imported by every checker file.
package fsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } fsc_state_t;

  localparam int DEF_IMG_W      = 584;
  localparam int DEF_IMG_H      = 388;
  localparam int DEF_PIX_W      = 8;
  localparam int DEF_NUM_IN     = 2;
  localparam int DEF_OUT_W      = 26;
  localparam int DEF_NUM_OUT    = 2;
  localparam int DEF_NUM_FRAMES = 1;
  localparam int DEF_SLACK      = 10;

  // Bits needed to address every pixel of a frame. Never narrower than one bit.
  function automatic int fsc_addr_w(input int size);
    return (size > 2) ? $clog2(size) : 1;
  endfunction

  localparam int DEF_ADDR_W = fsc_addr_w(DEF_IMG_W * DEF_IMG_H);

endpackage

// File: rtl/fsc_wrap_counter.sv
// Purpose: modulo-LIMIT position counter with a one-cycle wrap pulse.
// Latency: q updates one cycle after load/en; wrap is combinational from q and en.
// Backpressure: none; advances only when en is high.
// Ports: clk, reset (sync, active-low), load (restart at zero), en (advance),
//        q (current position), wrap (high in the cycle q steps LIMIT-1 -> 0).
module fsc_wrap_counter #(
  parameter int LIMIT = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] INC  = W'(1);
  // load together with en treats the current cycle as position 0, so the
  // following cycle already sits at position 1.
  localparam logic [W-1:0] AFTER_ZERO = (LIMIT > 1) ? W'(1) : '0;

  assign wrap = en && !load && (q == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= en ? AFTER_ZERO : '0;
    end else if (en) begin
      q <= (q == LAST) ? '0 : q + INC;
    end
  end

endmodule

// File: rtl/frame_stream_checker.sv
// Purpose: streams a source frame into a DUT and compares the DUT result stream
//          against expected data, reporting errors, sync faults and timeout.
// Latency: data_in/frame_sync_in are in_pix/offset-0 registered one cycle;
//          compare is same-cycle against exp_data.
// Backpressure: none; one pixel per cycle in STREAM, start ignored while busy.
// Ports: clk, reset (sync active-low), start; in_offset/in_pix source fetch;
//        frame_sync_in/data_in to DUT; frame_sync_out/data_out from DUT;
//        exp_offset/exp_data reference fetch; busy, done, pass, timeout,
//        sync_err, err_count, frame_count status.
// Build option: FSC_ALL_CHANNELS_EN compares every output channel; without it
//        only channel 0 is compared.
module frame_stream_checker
  import fsc_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int PIX_W       = DEF_PIX_W,
  parameter int NUM_IN      = DEF_NUM_IN,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int NUM_OUT     = DEF_NUM_OUT,
  parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int SLACK       = DEF_SLACK,
  localparam int IMG_SIZE   = IMG_W * IMG_H,
  localparam int ADDR_W     = fsc_addr_w(IMG_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [ADDR_W-1:0]          in_offset,
  input  logic [NUM_IN*PIX_W-1:0]    in_pix,
  output logic                       frame_sync_in,
  output logic [NUM_IN*PIX_W-1:0]    data_in,
  input  logic                       frame_sync_out,
  input  logic [NUM_OUT*OUT_W-1:0]   data_out,
  output logic [ADDR_W-1:0]          exp_offset,
  input  logic [NUM_OUT*OUT_W-1:0]   exp_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic                       sync_err,
  output logic [31:0]                err_count,
  output logic [15:0]                frame_count
);

  localparam logic [31:0] TMO_LIMIT = 32'(NUM_FRAMES * IMG_SIZE + SLACK * IMG_W);
  localparam logic [15:0] LAST_FRM  = 16'(NUM_FRAMES - 1);

  fsc_state_t state_q, state_d;

  logic        armed_q;
  logic [31:0] cyc_q;
  logic        start_acc;
  logic        in_stream;
  logic        cmp;
  logic        sync_hit;
  logic        mismatch;
  logic        exp_wrap;
  logic        in_wrap_unused;
  logic        last_wrap;
  logic        tmo_hit;
  logic [1:0]  err_inc;
  logic [32:0] err_sum;
  logic [31:0] err_nxt;

  assign in_stream = (state_q == ST_STREAM);
  assign start_acc = start && !in_stream;
  assign busy      = in_stream;

  // The first frame_sync_out both arms the checker and is itself a compare cycle.
  assign cmp      = in_stream && (armed_q || frame_sync_out);
  assign sync_hit = in_stream && armed_q && frame_sync_out && (exp_offset != '0);

  assign last_wrap = exp_wrap && (frame_count == LAST_FRM);
  // Fires in the first cycle whose count would exceed the budget. A final
  // frame wrap in the same cycle wins, the run completed in time.
  assign tmo_hit   = in_stream && !last_wrap && (cyc_q == TMO_LIMIT);

`ifdef FSC_ALL_CHANNELS_EN
  always_comb begin
    mismatch = 1'b0;
    for (int c = 0; c < NUM_OUT; c++) begin
      if (data_out[c*OUT_W +: OUT_W] != exp_data[c*OUT_W +: OUT_W]) begin
        mismatch = 1'b1;
      end
    end
  end
`else
  logic chan_unused;
  assign mismatch    = (data_out[OUT_W-1:0] != exp_data[OUT_W-1:0]);
  assign chan_unused = ^{data_out, exp_data};
`endif

  // A sync fault costs one error on top of any data mismatch that cycle.
  assign err_inc = {1'b0, cmp && mismatch} + {1'b0, sync_hit};
  assign err_sum = {1'b0, err_count} + {31'd0, err_inc};
  assign err_nxt = err_sum[32] ? '1 : err_sum[31:0];

  fsc_wrap_counter #(.LIMIT(IMG_SIZE), .W(ADDR_W)) u_in_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (start_acc),
    .en    (in_stream),
    .q     (in_offset),
    .wrap  (in_wrap_unused)
  );

  // A sync fault marks the current cycle as offset 0 again.
  fsc_wrap_counter #(.LIMIT(IMG_SIZE), .W(ADDR_W)) u_exp_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (start_acc || sync_hit),
    .en    (cmp),
    .q     (exp_offset),
    .wrap  (exp_wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_STREAM;
      ST_STREAM: if (last_wrap || tmo_hit) state_d = ST_DONE;
      ST_DONE:   if (start) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      cyc_q       <= '0;
      err_count   <= '0;
      frame_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        armed_q     <= 1'b0;
        cyc_q       <= '0;
        err_count   <= '0;
        frame_count <= '0;
        done        <= 1'b0;
        pass        <= 1'b0;
        timeout     <= 1'b0;
        sync_err    <= 1'b0;
      end else if (in_stream) begin
        cyc_q     <= cyc_q + 32'd1;
        err_count <= err_nxt;
        if (frame_sync_out) armed_q <= 1'b1;
        if (sync_hit) sync_err <= 1'b1;
        if (exp_wrap) frame_count <= frame_count + 16'd1;
        if (state_d == ST_DONE) begin
          done    <= 1'b1;
          timeout <= tmo_hit;
          pass    <= !tmo_hit && (err_nxt == '0) && !sync_err && !sync_hit;
        end
      end
    end
  end

  // Source stream register; frame_sync_in tags the word fetched at offset 0
  // and is never raised for a word captured on the way out of STREAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_in       <= '0;
      frame_sync_in <= 1'b0;
    end else if (in_stream) begin
      data_in       <= in_pix;
      frame_sync_in <= (state_d == ST_STREAM) && (in_offset == '0);
    end else begin
      frame_sync_in <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_stream_checker.sv
// Purpose: self-checking bench for frame_stream_checker on a 4x2 frame with a
//          3-cycle DUT model; table-driven runs plus hand-written corner sequences.
// Ports: none (top-level bench).
module tb_frame_stream_checker;
  import fsc_pkg::*;

  localparam int TIMG_W = 4;
  localparam int TIMG_H = 2;
  localparam int AW     = fsc_addr_w(TIMG_W * TIMG_H);

`ifdef FSC_ALL_CHANNELS_EN
  localparam int ALLCH = 1;
`else
  localparam int ALLCH = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] in_offset;
  logic [15:0]   in_pix;
  logic          frame_sync_in;
  logic [15:0]   data_in;
  logic          frame_sync_out;
  logic [51:0]   data_out;
  logic [AW-1:0] exp_offset;
  logic [51:0]   exp_data;
  logic          busy, done, pass, timeout, sync_err;
  logic [31:0]   err_count;
  logic [15:0]   frame_count;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  corr0, corr1;
  logic fs_en, force_fs;

  always #5 clk = ~clk;

  frame_stream_checker #(
    .IMG_W(TIMG_W), .IMG_H(TIMG_H), .PIX_W(8), .NUM_IN(2),
    .OUT_W(26), .NUM_OUT(2), .NUM_FRAMES(1), .SLACK(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_offset(in_offset), .in_pix(in_pix),
    .frame_sync_in(frame_sync_in), .data_in(data_in),
    .frame_sync_out(frame_sync_out), .data_out(data_out),
    .exp_offset(exp_offset), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .sync_err(sync_err), .err_count(err_count), .frame_count(frame_count)
  );

  // Source pixels: channel 0 = 2*off+1, channel 1 = 2*off+2.
  function automatic logic [15:0] pix(input int off);
    logic [7:0] p0, p1;
    p0 = 8'(off * 2 + 1);
    p1 = 8'(off * 2 + 2);
    return {p1, p0};
  endfunction

  // Reference transform of the modelled DUT.
  function automatic logic [51:0] xform(input logic [15:0] p);
    logic [25:0] c0, c1;
    c0 = 26'(p[7:0]) + 26'(p[15:8]) + 26'd100;
    c1 = 26'(p) * 26'd3;
    return {c1, c0};
  endfunction

  assign in_pix = pix(int'(in_offset));

  always_comb begin
    exp_data = xform(pix(int'(exp_offset)));
    if (int'(exp_offset) == corr0) exp_data[0]  = ~exp_data[0];
    if (int'(exp_offset) == corr1) exp_data[26] = ~exp_data[26];
  end

  // Three-stage DUT model.
  logic [51:0] pd0, pd1, pd2;
  logic        pf0, pf1, pf2;
  always @(posedge clk) begin
    if (!reset) begin
      pd0 <= '0; pd1 <= '0; pd2 <= '0;
      pf0 <= 1'b0; pf1 <= 1'b0; pf2 <= 1'b0;
    end else begin
      pd0 <= xform(data_in); pd1 <= pd0; pd2 <= pd1;
      pf0 <= frame_sync_in;  pf1 <= pf0; pf2 <= pf1;
    end
  end
  assign data_out       = pd2;
  assign frame_sync_out = (pf2 && fs_en) || force_fs;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; counts STREAM cycles seen along the way.
  task automatic wait_done(output int cyc);
    int n;
    cyc = 0;
    n   = 0;
    while (!done && n < 60) begin
      if (busy) cyc++;
      tick();
      n++;
    end
  endtask

  typedef struct {
    int c0;
    int c1;
    bit fs;
    bit e_pass;
    bit e_tmo;
    int e_err;
    int e_frm;
    int e_cyc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc;
    reset = 1'b0; start = 1'b0; force_fs = 1'b0; fs_en = 1'b1;
    corr0 = -1; corr1 = -1;

    //                c0  c1  fs  pass     tmo  err      frm cyc
    vecs[0] = '{     -1, -1, 1, 1'b1,      0,  0,        1, 12};
    vecs[1] = '{      5, -1, 1, 1'b0,      0,  1,        1, 12};
    vecs[2] = '{     -1,  2, 1, ALLCH==0,  0,  ALLCH,    1, 12};
    vecs[3] = '{      0,  7, 1, 1'b0,      0,  1+ALLCH,  1, 12};
    vecs[4] = '{     -1, -1, 0, 1'b0,      1,  0,        0, 13};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_in_offset", in_offset, 0);
    chk("rst_exp_offset", exp_offset, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_fsi", frame_sync_in, 0);
    reset = 1'b1;
    tick();

    // Stream timing, start while busy, offset wrap
    pulse_start();
    chk("s_t0_busy", busy, 1);
    chk("s_t0_in_offset", in_offset, 0);
    chk("s_t0_fsi", frame_sync_in, 0);
    tick();
    chk("s_t1_fsi", frame_sync_in, 1);
    chk("s_t1_data_in", data_in, pix(0));
    chk("s_t1_in_offset", in_offset, 1);
    tick();
    chk("s_t2_fsi", frame_sync_in, 0);
    chk("s_t2_data_in", data_in, pix(1));
    pulse_start();
    chk("s_t3_busy_ignore", busy, 1);
    chk("s_t3_in_offset", in_offset, 3);
    repeat (5) tick();
    chk("s_t8_in_offset_wrap", in_offset, 0);
    tick();
    chk("s_t9_fsi", frame_sync_in, 1);
    chk("s_t9_data_in", data_in, pix(0));
    wait_done(cyc);
    chk("s_done", done, 1);
    chk("s_pass", pass, 1);
    chk("s_done_fsi", frame_sync_in, 0);
    tick();
    chk("s_done_hold", done, 1);
    chk("s_done_fsi_hold", frame_sync_in, 0);
    pulse_start();
    chk("s_clear_done", done, 0);
    chk("s_clear_pass", pass, 0);

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      corr0 = vecs[i].c0;
      corr1 = vecs[i].c1;
      fs_en = vecs[i].fs;
      pulse_start();
      wait_done(cyc);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].e_pass);
      chk($sformatf("v%0d_timeout", i), timeout, vecs[i].e_tmo);
      chk($sformatf("v%0d_err_count", i), err_count, vecs[i].e_err);
      chk($sformatf("v%0d_frame_count", i), frame_count, vecs[i].e_frm);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].e_cyc);
      pulse_start();
      chk($sformatf("v%0d_idle_done", i), done, 0);
      repeat (4) tick();
    end
    corr0 = -1; corr1 = -1; fs_en = 1'b1;

    // Spurious frame_sync_out at exp_offset 3
    pulse_start();
    repeat (4) tick();
    chk("y_t4_exp_offset_arm", exp_offset, 0);
    repeat (3) tick();
    chk("y_t7_exp_offset", exp_offset, 3);
    chk("y_t7_sync_err", sync_err, 0);
    force_fs = 1'b1;
    tick();
    force_fs = 1'b0;
    chk("y_t8_sync_err", sync_err, 1);
    chk("y_t8_exp_offset_resync", exp_offset, 1);
    chk("y_t8_err_count", err_count, 1);
    wait_done(cyc);
    chk("y_done", done, 1);
    chk("y_pass", pass, 0);
    chk("y_timeout", timeout, 1);
    pulse_start();
    repeat (4) tick();

    // Mid-run reset at in_offset 5, then restart
    pulse_start();
    repeat (5) tick();
    chk("r_in_offset5", in_offset, 5);
    reset = 1'b0;
    tick();
    chk("r_busy", busy, 0);
    chk("r_in_offset", in_offset, 0);
    chk("r_exp_offset", exp_offset, 0);
    chk("r_data_in", data_in, 0);
    chk("r_fsi", frame_sync_in, 0);
    chk("r_err_count", err_count, 0);
    chk("r_done", done, 0);
    reset = 1'b1;
    tick();
    pulse_start();
    chk("r2_t0_in_offset", in_offset, 0);
    chk("r2_t0_busy", busy, 1);
    tick();
    chk("r2_t1_fsi", frame_sync_in, 1);
    chk("r2_t1_data_in", data_in, pix(0));
    wait_done(cyc);
    chk("r2_done", done, 1);
    chk("r2_pass", pass, 1);
    chk("r2_frame_count", frame_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
